// File: rtl/tensor_output_collector_if.sv
// Element stream in from the output adder and tagged word stream out to the next layer.
// The slave modport is the collector's view; master is the producer/consumer side.
interface tensor_output_collector_if #(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic             clear;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic             out_last;
  logic             frame_done;
  logic             sat_flag;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_col, out_last, frame_done, sat_flag
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_col, out_last, frame_done, sat_flag
  );
endinterface

// File: rtl/tensor_output_collector.sv
// Collects a ROWS x COLS frame of requantized elements, then drains it row-major with row/col/last tags.
// Optional feature macro TENSOR_COLLECT_SAT_EN: saturating requantization with sticky sat_flag (default: truncation).
module tensor_output_collector #(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input logic clk,
  input logic rst,
  tensor_output_collector_if.slave bus
);
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

`ifdef TENSOR_COLLECT_SAT_EN
  localparam longint SAT_MAX_L = (longint'(1) << (OUT_W - 1)) - longint'(1);
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'(SAT_MAX_L);
  localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-SAT_MAX_L - longint'(1));
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Returns {clipped, requantized value}.
  function automatic logic [OUT_W:0] requant(input logic signed [IN_W-1:0] d);
    logic [OUT_W:0] r;
`ifdef TENSOR_COLLECT_SAT_EN
    if (d > SAT_MAX) begin
      r = {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (d < SAT_MIN) begin
      r = {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      r = {1'b0, d[OUT_W-1:0]};
    end
`else
    r = {1'b0, d[OUT_W-1:0]};
`endif
    return r;
  endfunction

  state_t           state_r;
  logic [IDX_W-1:0] wr_idx_r;
  logic [IDX_W-1:0] rd_idx_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [OUT_W-1:0] out_data_r;
  logic [ROW_W-1:0] out_row_r;
  logic [COL_W-1:0] out_col_r;
  logic             out_last_r;
  logic             frame_done_r;
  logic             sat_r;
  logic [OUT_W-1:0] buf_r [N];

  logic             accept_s;
  logic [OUT_W:0]   quant_s;
  logic             clip_s;
  logic [OUT_W-1:0] qdata_s;
  logic [IDX_W-1:0] wr_next_s;
  logic [IDX_W-1:0] rd_next_s;

  assign accept_s  = bus.in_valid & in_ready_r;
  assign quant_s   = requant(bus.in_data);
  assign clip_s    = quant_s[OUT_W];
  assign qdata_s   = quant_s[OUT_W-1:0];
  assign wr_next_s = wr_idx_r + IDX_W'(1);
  assign rd_next_s = rd_idx_r + IDX_W'(1);

  // Frame FSM: fill buffer, then drain with registered outputs; clear acts like rst but keeps the buffer.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state_r      <= ST_IDLE;
      wr_idx_r     <= '0;
      rd_idx_r     <= '0;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_row_r    <= '0;
      out_col_r    <= '0;
      out_last_r   <= 1'b0;
      frame_done_r <= 1'b0;
      sat_r        <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_FILL: begin
          if (accept_s) begin
            buf_r[wr_idx_r] <= qdata_s;
            sat_r <= (state_r == ST_IDLE) ? clip_s : (sat_r | clip_s);
            if (wr_idx_r == LAST_IDX) begin
              // A single-element frame has its only word in flight, so bypass the buffer.
              state_r     <= ST_DRAIN;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
              rd_idx_r    <= '0;
              out_row_r   <= '0;
              out_col_r   <= '0;
              out_data_r  <= (N == 1) ? qdata_s : buf_r[0];
              out_last_r  <= (N == 1) ? 1'b1 : 1'b0;
            end else begin
              wr_idx_r <= wr_next_s;
              state_r  <= ST_FILL;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.out_ready) begin
            if (out_last_r) begin
              state_r      <= ST_IDLE;
              wr_idx_r     <= '0;
              rd_idx_r     <= '0;
              in_ready_r   <= 1'b1;
              out_valid_r  <= 1'b0;
              out_last_r   <= 1'b0;
              out_data_r   <= '0;
              out_row_r    <= '0;
              out_col_r    <= '0;
              frame_done_r <= 1'b1;
            end else begin
              rd_idx_r   <= rd_next_s;
              out_data_r <= buf_r[rd_next_s];
              out_last_r <= (rd_next_s == LAST_IDX);
              if (out_col_r == LAST_COL) begin
                out_col_r <= '0;
                out_row_r <= out_row_r + ROW_W'(1);
              end else begin
                out_col_r <= out_col_r + COL_W'(1);
              end
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          wr_idx_r    <= '0;
          rd_idx_r    <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_row    = out_row_r;
  assign bus.out_col    = out_col_r;
  assign bus.out_last   = out_last_r;
  assign bus.frame_done = frame_done_r;
  assign bus.sat_flag   = sat_r;
endmodule
